alu_cmd_sequencer: RTL and testbench

Command-side driver and result collector for the 4-bit combinational ALU (a, b, sel -> result).
- Accepts operation commands over a valid/ready handshake and holds a small operand register file.
- Drives registered operands and opcode onto the ALU, captures the ALU result into a destination register, and returns it on a valid/ready response channel.
- Sits between the control/test front end and the ALU instance.

---
 rtl/alu_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a 4-bit combinational ALU: operand register file, registered
// ALU drive, result capture and response channel. Optional rsp_zero under ALU_FLAGS_EN.
module alu_cmd_sequencer #(
  parameter int DW       = 4,
  parameter int RF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [1:0]    cmd_dst,
  input  logic [1:0]    cmd_src_a,
  input  logic [1:0]    cmd_src_b,
  input  logic [DW-1:0] cmd_imm,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [1:0]    rsp_dst,
`ifdef ALU_FLAGS_EN
  output logic          rsp_zero,
`endif
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_result
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] OP_LDI = 3'b111;

  state_t        state_q, state_d;
  logic [DW-1:0] rf_q [RF_DEPTH];
  logic [DW-1:0] rf_d [RF_DEPTH];
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]    rsp_dst_q, rsp_dst_d;
  logic          rsp_zero_q, rsp_zero_d;
  logic [1:0]    dst_q, dst_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [2:0]    alu_sel_q, alu_sel_d;

  // Write-back value and index shared by the LDI and EXEC paths
  logic          wb_en;
  logic [DW-1:0] wb_val;
  logic [1:0]    wb_dst;

  always_comb begin
    state_d     = state_q;
    rf_d        = rf_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_dst_d   = rsp_dst_q;
    rsp_zero_d  = rsp_zero_q;
    dst_d       = dst_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    wb_en       = 1'b0;
    wb_val      = '0;
    wb_dst      = '0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          dst_d       = cmd_dst;
          if (cmd_op == OP_LDI) begin
            wb_en   = 1'b1;
            wb_val  = cmd_imm;
            wb_dst  = cmd_dst;
            state_d = RESP;
          end else begin
            alu_a_d   = rf_q[cmd_src_a];
            alu_b_d   = rf_q[cmd_src_b];
            alu_sel_d = cmd_op;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        wb_en   = 1'b1;
        wb_val  = alu_result;
        wb_dst  = dst_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wb_en) begin
      rf_d[wb_dst] = wb_val;
      rsp_data_d   = wb_val;
      rsp_dst_d    = wb_dst;
      rsp_zero_d   = (wb_val == '0);
      rsp_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_dst_q   <= '0;
      rsp_zero_q  <= 1'b0;
      dst_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      rf_q        <= rf_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_dst_q   <= rsp_dst_d;
      rsp_zero_q  <= rsp_zero_d;
      dst_q       <= dst_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_dst   = rsp_dst_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;

`ifdef ALU_FLAGS_EN
  assign rsp_zero = rsp_zero_q;
`else
  logic unused_zero;
  assign unused_zero = rsp_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_cmd_sequencer;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] NOTB = 3'b100, OP6 = 3'b110, LDI = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_dst = '0, cmd_src_a = '0, cmd_src_b = '0;
  logic [3:0] cmd_imm = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_data;
  logic [1:0] rsp_dst;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
`ifdef ALU_FLAGS_EN
  logic       rsp_zero;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DW(4), .RF_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_dst(cmd_dst),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_dst(rsp_dst),
`ifdef ALU_FLAGS_EN
    .rsp_zero(rsp_zero),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result)
  );

  // Standard ALU: ops 101/110 return zero
  always_comb begin
    case (alu_sel)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = ~alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_dst"}, rsp_dst, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_sel"}, alu_sel, 0);
`ifdef ALU_FLAGS_EN
    check({tag, "_rsp_zero"}, rsp_zero, 0);
`endif
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, cmd_ready, 1);
  endtask

  // Issue one command with rsp_ready held high and check latency, operands and response
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [1:0] dst,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] imm,
                        input logic [3:0] exp_a, input logic [3:0] exp_b,
                        input logic [3:0] exp_data);
    wait_ready(tag);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst;
    cmd_src_a = sa; cmd_src_b = sb; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check({tag, "_accept_ready"}, cmd_ready, 0);
    if (op == LDI) begin
      check({tag, "_ldi_lat"}, rsp_valid, 1);
    end else begin
      check({tag, "_exec_valid"}, rsp_valid, 0);
      check({tag, "_alu_a"}, alu_a, exp_a);
      check({tag, "_alu_b"}, alu_b, exp_b);
      check({tag, "_alu_sel"}, alu_sel, op);
      @(posedge clk); #1;
      check({tag, "_alu_lat"}, rsp_valid, 1);
    end
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_dst"}, rsp_dst, dst);
`ifdef ALU_FLAGS_EN
    check({tag, "_zero"}, rsp_zero, exp_data == 4'h0);
`endif
    @(posedge clk); #1;
    check({tag, "_rsp_done"}, rsp_valid, 0);
    check({tag, "_ready_back"}, cmd_ready, 1);
  endtask

  initial begin
    #2;
    check_idle_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    #1 check("pre_edge_ready", cmd_ready, 0);
    @(posedge clk); #1;
    check("first_edge_ready", cmd_ready, 1);

    do_cmd("ldi_r0", LDI, 2'd0, 2'd0, 2'd0, 4'h5, 4'h0, 4'h0, 4'h5);
    do_cmd("ldi_r1", LDI, 2'd1, 2'd0, 2'd0, 4'h3, 4'h0, 4'h0, 4'h3);
    do_cmd("add",    ADD, 2'd2, 2'd0, 2'd1, 4'h0, 4'h5, 4'h3, 4'h8);
    do_cmd("sub_wr", SUB, 2'd3, 2'd1, 2'd0, 4'h0, 4'h3, 4'h5, 4'hE);
    do_cmd("sub_z",  SUB, 2'd3, 2'd0, 2'd0, 4'h0, 4'h5, 4'h5, 4'h0);

    do_cmd("ldi_c",  LDI, 2'd0, 2'd0, 2'd0, 4'hC, 4'h0, 4'h0, 4'hC);
    do_cmd("ldi_a",  LDI, 2'd1, 2'd0, 2'd0, 4'hA, 4'h0, 4'h0, 4'hA);
    do_cmd("and",    AND_, 2'd2, 2'd0, 2'd1, 4'h0, 4'hC, 4'hA, 4'h8);
    do_cmd("or",     OR_,  2'd2, 2'd0, 2'd1, 4'h0, 4'hC, 4'hA, 4'hE);
    do_cmd("notb",   NOTB, 2'd2, 2'd0, 2'd1, 4'h0, 4'hC, 4'hA, 4'h5);
    do_cmd("op6",    OP6,  2'd2, 2'd0, 2'd1, 4'h0, 4'hC, 4'hA, 4'h0);

    // dst aliases src: old r0=C read, r0 becomes 8; next op must see 8
    do_cmd("alias",  ADD, 2'd0, 2'd0, 2'd0, 4'h0, 4'hC, 4'hC, 4'h8);
    do_cmd("alias2", ADD, 2'd2, 2'd0, 2'd1, 4'h0, 4'h8, 4'hA, 4'h2);

    // Backpressure: response held, second command (LDI r1=9) must be ignored
    wait_ready("bp");
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = LDI; cmd_dst = 2'd2; cmd_imm = 4'h7;
    @(posedge clk); #1;
    cmd_dst = 2'd1; cmd_imm = 4'h9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 4'h7);
      check("bp_dst", rsp_dst, 2'd2);
      check("bp_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_ready", cmd_ready, 1);
    do_cmd("bp_r1", ADD, 2'd3, 2'd2, 2'd1, 4'h0, 4'h7, 4'hA, 4'h1);

    // Reset during EXEC: everything cleared, no response, register file zeroed
    wait_ready("rst");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_dst = 2'd2; cmd_src_a = 2'd0; cmd_src_b = 2'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("rst_in_exec_sel", alu_a, 4'h8);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 check("midrst_no_rsp", rsp_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    do_cmd("post_rst", ADD, 2'd2, 2'd0, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
